and2_formal_top: RTL and testbench

AND2_FORMAL_TOP -- requirements
Module: and2_formal_top

---
 rtl/and2_formal_top.sv | 131 +++++++++++++
 tb/tb_and2_formal_top.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and2_formal_top.sv
// ---------------------------------------------------------------------------
// and2_formal_top
//
// Purpose:
//    A single 2-input LUT cell ("fabric") that powers up as an AND gate, plus a
//    hard-wired AND reference. A registered compare flag watches the two
//    results, and an optional saturating counter tallies each time the flag
//    rises. The LUT can be reprogrammed serially, MSB first, so a deliberately
//    wrong table can be loaded to exercise the checker.
//
// Configuration macro:
//    AND2_ERR_COUNT_EN  - when defined, build the mismatch edge detector and
//                         the saturating err_count. When undefined, err_count
//                         is tied to zero and neither register is built.
//
// Parameters:
//    CNT_W      - err_count width, legal range 2..32 (default 16)
//
// Ports:
//    clk        - in  : single clock, rising edge
//    reset      - in  : synchronous, active-high
//    a, b       - in  : operands
//    cfg_en     - in  : LUT shift enable
//    cfg_din    - in  : serial LUT data, shifted in at the LSB
//    c          - out : LUT result lut[{b,a}], combinational
//    c_ref      - out : reference a & b, combinational
//    mismatch   - out : registered compare flag
//    err_count  - out : number of mismatch rising edges, saturating
// ---------------------------------------------------------------------------
module and2_formal_top #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a,
   input  logic             b,
   input  logic             cfg_en,
   input  logic             cfg_din,
   output logic             c,
   output logic             c_ref,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_count
);

   // Reset table: only index {b,a}=2'b11 yields 1, i.e. an AND gate.
   localparam logic [3:0] LUT_AND = 4'b1000;

   logic [3:0] lut_q;
   logic [3:0] lut_d;
   logic       chk_arm_q;
   logic       mismatch_q;
   logic       mismatch_d;

   // The datapath is purely combinational so c and c_ref follow a/b even
   // while reset is held.
   assign c     = lut_q[{b, a}];
   assign c_ref = a & b;

   // Shift register next state. New bits enter at the LSB, so after four
   // enabled cycles the first bit shifted in sits at lut[3].
   // The compare is suppressed until the arm flag is set (the cycle right
   // after reset is skipped) and whenever the table is being rewritten,
   // since a half-loaded table is expected to disagree with the reference.
   always_comb begin
      lut_d      = lut_q;
      mismatch_d = 1'b0;
      if (cfg_en) begin
         lut_d = {lut_q[2:0], cfg_din};
      end
      if (chk_arm_q && !cfg_en) begin
         mismatch_d = c ^ c_ref;
      end
   end

   // Core state. Reset wins over cfg_en, which also throws away any partial
   // shift that was in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         lut_q      <= LUT_AND;
         chk_arm_q  <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         lut_q      <= lut_d;
         chk_arm_q  <= 1'b1;
         mismatch_q <= mismatch_d;
      end
   end

   assign mismatch = mismatch_q;

`ifdef AND2_ERR_COUNT_EN

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             mismatch_prev_q;
   logic             mismatch_rise;
   logic [CNT_W-1:0] err_count_q;
   logic [CNT_W-1:0] err_count_d;

   // A held mismatch is one event: only a 0->1 step of the registered flag
   // counts, so the count lands one cycle after the flag rises.
   // The counter sticks at all-ones rather than wrapping back to zero.
   always_comb begin
      mismatch_rise = mismatch_q & ~mismatch_prev_q;
      err_count_d   = err_count_q;
      if (mismatch_rise && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + CNT_ONE;
      end
   end

   // Event detector and counter registers; only reset clears the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         mismatch_prev_q <= 1'b0;
         err_count_q     <= '0;
      end else begin
         mismatch_prev_q <= mismatch_q;
         err_count_q     <= err_count_d;
      end
   end

   assign err_count = err_count_q;

`else

   assign err_count = '0;

`endif

endmodule

// File: tb/tb_and2_formal_top.sv
// ---------------------------------------------------------------------------
// tb_and2_formal_top
//
// Directed bench for and2_formal_top. Two instances share the same stimulus:
// dut uses the default 16-bit counter and dut2 a 2-bit counter so that
// saturation is reachable in a handful of events. Expected counts are zero
// unless AND2_ERR_COUNT_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_and2_formal_top;

`ifdef AND2_ERR_COUNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        a;
   logic        b;
   logic        cfgEn;
   logic        cfgDin;
   logic        c;
   logic        cRef;
   logic        mismatch;
   logic [15:0] errCount;
   logic        c2;
   logic        cRef2;
   logic        mismatch2;
   logic [1:0]  errCount2;

   int vectors;
   int miscompares;

   and2_formal_top dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .cfg_en    (cfgEn),
      .cfg_din   (cfgDin),
      .c         (c),
      .c_ref     (cRef),
      .mismatch  (mismatch),
      .err_count (errCount)
   );

   and2_formal_top #(.CNT_W(2)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .cfg_en    (cfgEn),
      .cfg_din   (cfgDin),
      .c         (c2),
      .c_ref     (cRef2),
      .mismatch  (mismatch2),
      .err_count (errCount2)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int expErr(input int n);
      return ERR_EN ? n : 0;
   endfunction

   // Apply a one-edge reset and release it.
   task automatic pulseReset();
      reset = 1'b1;
      cfgEn = 1'b0;
      step();
      reset = 1'b0;
   endtask

   // Shift the OR table 4'b1110 in, MSB first (four edges).
   task automatic loadOr();
      logic [3:0] pattern;
      pattern = 4'b1110;
      cfgEn = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         cfgDin = pattern[i];
         step();
      end
      cfgEn  = 1'b0;
      cfgDin = 1'b0;
   endtask

   // Reset priority over cfg_en, reset values and combinational outputs
   task automatic test_reset();
      reset  = 1'b1;
      cfgEn  = 1'b1;
      cfgDin = 1'b0;
      a      = 1'b1;
      b      = 1'b1;
      step();
      step();
      vectors++;
      if (c !== 1'b1 || cRef !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_and11: c=%b c_ref=%b, required c=1 c_ref=1", c, cRef);
      end
      vectors++;
      if (mismatch !== 1'b0 || errCount !== 16'd0 || errCount2 !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: mismatch=%b err=%0d err2=%0d, required 0/0/0",
                  mismatch, errCount, errCount2);
      end
      a = 1'b0;
      #1;
      vectors++;
      if (c !== 1'b0 || cRef !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_and01: c=%b c_ref=%b, required 0/0", c, cRef);
      end
      cfgEn = 1'b0;
      reset = 1'b0;
      step();
   endtask

   // AND table walk: fabric and reference agree on every input pattern
   task automatic test_and_table();
      logic expC;
      for (int i = 0; i < 4; i++) begin
         a    = i[0];
         b    = i[1];
         expC = (i == 3);
         #1;
         vectors++;
         if (c !== expC || cRef !== expC) begin
            miscompares++;
            $display("[TB] FAIL and_table ab=%b%b: c=%b c_ref=%b, required %b", a, b, c, cRef, expC);
         end
         step();
         vectors++;
         if (mismatch !== 1'b0 || errCount !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL and_table_mm ab=%b%b: mismatch=%b err=%0d, required 0/0",
                     a, b, mismatch, errCount);
         end
      end
   endtask

   // OR table loaded, single held mismatch counts once
   task automatic test_or_mismatch();
      a = 1'b0;
      b = 1'b0;
      loadOr();
      a = 1'b1;
      #1;
      vectors++;
      if (c !== 1'b1 || cRef !== 1'b0 || mismatch !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL or_comb: c=%b c_ref=%b mismatch=%b, required 1/0/0", c, cRef, mismatch);
      end
      step();
      vectors++;
      if (mismatch !== 1'b1 || errCount !== 16'(expErr(0))) begin
         miscompares++;
         $display("[TB] FAIL or_rise: mismatch=%b err=%0d, required 1/%0d", mismatch, errCount, expErr(0));
      end
      step();
      vectors++;
      if (errCount !== 16'(expErr(1))) begin
         miscompares++;
         $display("[TB] FAIL or_count: err=%0d, required %0d", errCount, expErr(1));
      end
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++;
         if (mismatch !== 1'b1 || errCount !== 16'(expErr(1))) begin
            miscompares++;
            $display("[TB] FAIL or_hold%0d: mismatch=%b err=%0d, required 1/%0d",
                     i, mismatch, errCount, expErr(1));
         end
      end
   endtask

   // Toggling a mismatching input gives one event per pulse
   task automatic test_toggle();
      a = 1'b0;
      b = 1'b0;
      pulseReset();
      loadOr();
      for (int i = 0; i < 6; i++) begin
         a = (i % 2 == 0);
         step();
         vectors++;
         if (mismatch !== (i % 2 == 0)) begin
            miscompares++;
            $display("[TB] FAIL toggle%0d: mismatch=%b, required %b", i, mismatch, (i % 2 == 0));
         end
      end
      a = 1'b0;
      step();
      vectors++;
      if (errCount !== 16'(expErr(3)) || errCount2 !== 2'(expErr(3))) begin
         miscompares++;
         $display("[TB] FAIL toggle_count: err=%0d err2=%0d, required %0d", errCount, errCount2, expErr(3));
      end
   endtask

   // First cycle after reset is never checked; compare resumes afterwards
   task automatic test_first_cycle_skip();
      a = 1'b1;
      b = 1'b0;
      pulseReset();
      step();
      vectors++;
      if (mismatch !== 1'b0 || errCount !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL skip_first: mismatch=%b err=%0d, required 0/0", mismatch, errCount);
      end
      loadOr();
      vectors++;
      if (mismatch !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL skip_cfg: mismatch=%b, required 0", mismatch);
      end
      step();
      vectors++;
      if (mismatch !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL skip_rise: mismatch=%b, required 1", mismatch);
      end
      step();
      vectors++;
      if (errCount !== 16'(expErr(1))) begin
         miscompares++;
         $display("[TB] FAIL skip_count: err=%0d, required %0d", errCount, expErr(1));
      end
   endtask

   // cfg_en masks the compare; reset mid-shift restores the AND table
   task automatic test_cfg_masks();
      logic [3:0] pattern;
      logic       expC;
      pattern = 4'b1110;
      cfgEn   = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         cfgDin = pattern[i];
         step();
         vectors++;
         if (mismatch !== 1'b0 || errCount !== 16'(expErr(1))) begin
            miscompares++;
            $display("[TB] FAIL cfg_mask%0d: mismatch=%b err=%0d, required 0/%0d",
                     i, mismatch, errCount, expErr(1));
         end
      end
      cfgEn = 1'b0;
      step();
      step();
      vectors++;
      if (mismatch !== 1'b1 || errCount !== 16'(expErr(2))) begin
         miscompares++;
         $display("[TB] FAIL cfg_after: mismatch=%b err=%0d, required 1/%0d", mismatch, errCount, expErr(2));
      end
      cfgEn  = 1'b1;
      cfgDin = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      cfgEn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a    = i[0];
         b    = i[1];
         expC = (i == 3);
         #1;
         vectors++;
         if (c !== expC) begin
            miscompares++;
            $display("[TB] FAIL midshift_lut ab=%b%b: c=%b, required %b", a, b, c, expC);
         end
      end
      vectors++;
      if (errCount !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL midshift_err: err=%0d, required 0", errCount);
      end
   endtask

   // Five events: the 2-bit counter sticks at 3, the 16-bit one reaches 5
   task automatic test_saturation();
      a = 1'b0;
      b = 1'b0;
      pulseReset();
      loadOr();
      for (int i = 0; i < 10; i++) begin
         a = (i % 2 == 0);
         step();
      end
      a = 1'b0;
      step();
      vectors++;
      if (errCount2 !== 2'(expErr(3))) begin
         miscompares++;
         $display("[TB] FAIL sat_cnt2: err2=%0d, required %0d", errCount2, expErr(3));
      end
      vectors++;
      if (errCount !== 16'(expErr(5))) begin
         miscompares++;
         $display("[TB] FAIL sat_cnt16: err=%0d, required %0d", errCount, expErr(5));
      end
      vectors++;
      if (c2 !== c || cRef2 !== cRef || mismatch2 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sat_dut2: c2=%b c_ref2=%b mismatch2=%b, required %b/%b/0",
                  c2, cRef2, mismatch2, c, cRef);
      end
   endtask

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      a           = 1'b0;
      b           = 1'b0;
      cfgEn       = 1'b0;
      cfgDin      = 1'b0;
      test_reset();
      test_and_table();
      test_or_mismatch();
      test_toggle();
      test_first_cycle_skip();
      test_cfg_masks();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
